// File: rtl/noc_sim_sequencer.sv
// rtl/noc_sim_sequencer.sv - NoC simulator phase sequencer driving the shared op bus and cycle count
module noc_sim_sequencer #(
    parameter int NUM_ROUTERS = 16,
    parameter int RT_ENTRIES  = 16,
    parameter int CYC_W       = 16,
    parameter int OP_W        = 3,
    localparam int RT_W       = $clog2(RT_ENTRIES)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [CYC_W-1:0]       i_max_cycles,
    input  logic [NUM_ROUTERS-1:0] i_done_vec,
    output logic [OP_W-1:0]        o_op,
    output logic [RT_W-1:0]        o_rt_addr,
    output logic [CYC_W-1:0]       o_in_cycle,
    output logic                   o_busy,
    output logic                   o_finished,
    output logic                   o_timeout
);

    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_INIT = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LRT  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LSTG = OP_W'(3);
    localparam logic [OP_W-1:0] OP_PH0  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_PH1  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_COPY = OP_W'(6);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_LOAD_RT,
        S_LOAD_STG,
        S_PH0,
        S_PH1,
        S_COPY,
        S_CHECK,
        S_FINISH
    } state_t;

    state_t            r_state;
    logic [OP_W-1:0]   r_op;
    logic [RT_W-1:0]   r_rt_addr;
    logic [CYC_W-1:0]  r_in_cycle;
    logic [CYC_W-1:0]  r_budget;
    logic              r_busy;
    logic              r_finished;
    logic              r_timeout;

    logic w_all_done;
    logic w_budget_hit;

    // Completion conditions evaluated in CHECK; a zero budget never expires
    assign w_all_done   = &i_done_vec;
    assign w_budget_hit = (r_budget != '0) && (r_in_cycle == (r_budget - CYC_W'(1)));

    // Sequencer FSM; op/busy/finished are registered together with the next state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_op       <= OP_NOP;
            r_rt_addr  <= '0;
            r_in_cycle <= '0;
            r_budget   <= '0;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_FINISH: begin
                    if (i_start) begin
                        r_state    <= S_INIT;
                        r_op       <= OP_INIT;
                        r_budget   <= i_max_cycles;
                        r_in_cycle <= '0;
                        r_rt_addr  <= '0;
                        r_timeout  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_finished <= 1'b0;
                    end
                end
                S_INIT: begin
                    r_state <= S_LOAD_RT;
                    r_op    <= OP_LRT;
                end
                S_LOAD_RT: begin
                    if (r_rt_addr == RT_W'(RT_ENTRIES - 1)) begin
                        r_rt_addr <= '0;
                        r_state   <= S_LOAD_STG;
                        r_op      <= OP_LSTG;
                    end else begin
                        r_rt_addr <= r_rt_addr + RT_W'(1);
                    end
                end
                S_LOAD_STG: begin
                    r_state <= S_PH0;
                    r_op    <= OP_PH0;
                end
                S_PH0: begin
                    r_state <= S_PH1;
                    r_op    <= OP_PH1;
                end
                S_PH1: begin
                    r_state <= S_COPY;
                    r_op    <= OP_COPY;
                end
                S_COPY: begin
                    r_state <= S_CHECK;
                    r_op    <= OP_NOP;
                end
                S_CHECK: begin
                    if (w_all_done || w_budget_hit) begin
                        r_state    <= S_FINISH;
                        r_op       <= OP_NOP;
                        r_busy     <= 1'b0;
                        r_finished <= 1'b1;
                        r_timeout  <= ~w_all_done;
                    end else begin
                        // in_cycle only moves here so it is stable across all four ops
                        r_in_cycle <= r_in_cycle + CYC_W'(1);
                        r_state    <= S_LOAD_STG;
                        r_op       <= OP_LSTG;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_op       <= OP_NOP;
                    r_busy     <= 1'b0;
                    r_finished <= 1'b0;
                end
            endcase
        end
    end

    assign o_op       = r_op;
    assign o_rt_addr  = r_rt_addr;
    assign o_in_cycle = r_in_cycle;
    assign o_busy     = r_busy;
    assign o_finished = r_finished;
    assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_noc_sim_sequencer.sv
// tb/tb_noc_sim_sequencer.sv - directed self-checking bench for noc_sim_sequencer
module tb_noc_sim_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] max_cycles = '0;
    logic [15:0] done_vec = '0;
    logic [2:0]  op;
    logic [3:0]  rt_addr;
    logic [15:0] in_cycle;
    logic        busy, finished, timeout;

    logic        start2 = 1'b0;
    logic [3:0]  max2 = '0;
    logic [15:0] done2 = '0;
    logic [2:0]  op2;
    logic [3:0]  rt_addr2;
    logic [3:0]  in_cycle2;
    logic        busy2, finished2, timeout2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    noc_sim_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_max_cycles(max_cycles),
        .i_done_vec(done_vec), .o_op(op), .o_rt_addr(rt_addr), .o_in_cycle(in_cycle),
        .o_busy(busy), .o_finished(finished), .o_timeout(timeout)
    );

    noc_sim_sequencer #(.CYC_W(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .i_max_cycles(max2),
        .i_done_vec(done2), .o_op(op2), .o_rt_addr(rt_addr2), .o_in_cycle(in_cycle2),
        .o_busy(busy2), .o_finished(finished2), .o_timeout(timeout2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        tick(); tick();
        chk("rst_op", 32'(op), 0);
        chk("rst_rt_addr", 32'(rt_addr), 0);
        chk("rst_in_cycle", 32'(in_cycle), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_finished", 32'(finished), 0);
        chk("rst_timeout", 32'(timeout), 0);
        rst = 1'b0;
        tick();
        chk("idle_op", 32'(op), 0);

        // reset in the middle of LOAD_RT
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mid_init_op", 32'(op), 1);
        chk("mid_init_busy", 32'(busy), 1);
        for (int k = 0; k < 8; k++) tick();
        chk("mid_rt_addr", 32'(rt_addr), 7);
        chk("mid_rt_op", 32'(op), 2);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_op", 32'(op), 0);
        chk("async_rst_rt_addr", 32'(rt_addr), 0);
        chk("async_rst_busy", 32'(busy), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_op", 32'(op), 0);

        // all-done at the first CHECK
        max_cycles = 16'd0;
        done_vec   = 16'hFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("r1_init", 32'(op), 1);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("r1_lrt_op", 32'(op), 2);
            chk("r1_lrt_addr", 32'(rt_addr), 32'(k));
        end
        tick(); chk("r1_lstg", 32'(op), 3);
        chk("r1_lstg_addr", 32'(rt_addr), 0);
        tick(); chk("r1_ph0", 32'(op), 4);
        tick(); chk("r1_ph1", 32'(op), 5);
        tick(); chk("r1_copy", 32'(op), 6);
        tick(); chk("r1_check", 32'(op), 0);
        chk("r1_check_busy", 32'(busy), 1);
        tick();
        chk("r1_finished", 32'(finished), 1);
        chk("r1_timeout", 32'(timeout), 0);
        chk("r1_in_cycle", 32'(in_cycle), 0);
        chk("r1_busy", 32'(busy), 0);
        tick();
        chk("r1_hold_finished", 32'(finished), 1);

        // budget of 3 cycles, never done
        max_cycles = 16'd3;
        done_vec   = 16'h0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        max_cycles = 16'd0;
        chk("r2_init", 32'(op), 1);
        chk("r2_finished_clr", 32'(finished), 0);
        for (int k = 0; k < 16; k++) tick();
        for (int c = 0; c < 3; c++) begin
            tick(); chk("r2_lstg", 32'(op), 3);
            chk("r2_cycle", 32'(in_cycle), 32'(c));
            tick(); tick(); tick();
            chk("r2_copy_cycle", 32'(in_cycle), 32'(c));
            tick(); chk("r2_check", 32'(op), 0);
        end
        tick();
        chk("r2_finished", 32'(finished), 1);
        chk("r2_timeout", 32'(timeout), 1);
        chk("r2_in_cycle", 32'(in_cycle), 2);
        chk("r2_op", 32'(op), 0);

        // start from FINISH clears timeout; done outside CHECK ignored; start while busy ignored
        done_vec = 16'hFFFE;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("r3_init", 32'(op), 1);
        chk("r3_timeout_clr", 32'(timeout), 0);
        chk("r3_in_cycle_clr", 32'(in_cycle), 0);
        for (int k = 0; k < 16; k++) tick();
        for (int c = 0; c < 4; c++) begin
            tick(); chk("r3_lstg", 32'(op), 3);
            chk("r3_cycle", 32'(in_cycle), 32'(c));
            done_vec = 16'hFFFF;
            tick(); chk("r3_ph0", 32'(op), 4);
            if (c == 1) start = 1'b1;
            tick(); chk("r3_ph1", 32'(op), 5);
            start = 1'b0;
            done_vec = 16'hFFFE;
            tick(); chk("r3_copy", 32'(op), 6);
            if (c == 3) done_vec = 16'hFFFF;
            else        done_vec = 16'hFFFE;
            tick(); chk("r3_check", 32'(op), 0);
            chk("r3_check_fin", 32'(finished), 0);
        end
        tick();
        chk("r3_finished", 32'(finished), 1);
        chk("r3_timeout", 32'(timeout), 0);
        chk("r3_in_cycle", 32'(in_cycle), 3);

        // 4-bit cycle counter wraps and keeps looping
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("w_init", 32'(op2), 1);
        for (int k = 0; k < 16; k++) tick();
        for (int c = 0; c < 18; c++) begin
            tick();
            chk("w_lstg", 32'(op2), 3);
            chk("w_cycle", 32'(in_cycle2), 32'(c % 16));
            chk("w_busy", 32'(busy2), 1);
            if (c < 17) begin
                tick(); tick(); tick(); tick();
            end
        end
        chk("w_not_finished", 32'(finished2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
